iter_muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit; WIDTH-generic companion to the single-cycle integer ALU.

---
 rtl/iter_muldiv_unit.sv | 275 +++++++++++++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : iter_muldiv_unit
// Brief    : Iterative multiply/divide unit for the integer pipeline.
//            Executes mullw, mulhw, mulhwu, divw and divwu one bit per cycle
//            behind a start/done handshake, with flush abort and OV/CR0 flags.
// Revision : 1.0 - initial release
// ============================================================================
module iter_muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter int OP_WIDTH  = 3,
    parameter int CNT_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                flush,
    input  logic [OP_WIDTH-1:0] Op,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    C,
    output logic [3:0]          D
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [OP_WIDTH-1:0]  c_op_mullw  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0]  c_op_mulhw  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0]  c_op_mulhwu = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0]  c_op_divw   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0]  c_op_divwu  = OP_WIDTH'(5);
    localparam logic [WIDTH-1:0]     c_int_min   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] c_last_iter = CNT_WIDTH'(WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [OP_WIDTH-1:0]    op_q,    op_d;
    logic [WIDTH-1:0]       bmag_q,  bmag_d;    // |B| (or raw B for unsigned ops)
    logic [2*WIDTH-1:0]     acc_q,   acc_d;     // product, or {remainder, quotient}
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;     // iterations remaining minus one
    logic                   neg_q,   neg_d;     // result needs negation
    logic                   fast_q,  fast_d;    // divide-by-zero / overflow bypass
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
    logic [WIDTH-1:0]       res_q,   res_d;
    logic [3:0]             flags_q, flags_d;

    // ------------------------------------------------------------------------
    // Operand decode at capture time
    // ------------------------------------------------------------------------
    logic             w_op_mul;
    logic             w_op_div;
    logic             w_op_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_fast;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    // Classify the incoming op and form operand magnitudes
    always_comb begin
        w_op_mul    = (Op == c_op_mullw) || (Op == c_op_mulhw) || (Op == c_op_mulhwu);
        w_op_div    = (Op == c_op_divw)  || (Op == c_op_divwu);
        w_op_signed = (Op == c_op_mullw) || (Op == c_op_mulhw) || (Op == c_op_divw);
        w_a_neg     = w_op_signed & A[WIDTH-1];
        w_b_neg     = w_op_signed & B[WIDTH-1];
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude, so no special case is needed here.
        w_a_mag     = w_a_neg ? -A : A;
        w_b_mag     = w_b_neg ? -B : B;
        w_fast      = w_op_div &&
                      ((B == '0) ||
                       ((Op == c_op_divw) && (A == c_int_min) && (B == '1)));
    end

    // ------------------------------------------------------------------------
    // One iteration step of each algorithm
    // ------------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic [2*WIDTH-1:0]   w_div_step;

    // Shift-add multiply and restoring divide, one bit per call
    always_comb begin
        // Multiply: LSB of the low half is the current multiplier bit; the
        // carry out of the upper-half add shifts down with the product.
        w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (acc_q[0] ? bmag_q : {WIDTH{1'b0}})};
        w_mul_step = {w_mul_sum, acc_q[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the partial remainder and
        // subtract the divisor when it fits.  The remainder stays below the
        // divisor, so the shifted value needs one extra bit only transiently.
        w_rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        w_div_ge   = (w_rem_sh >= {1'b0, bmag_q});
        w_rem_sub  = WIDTH'(w_rem_sh - {1'b0, bmag_q});
        w_div_step = w_div_ge ? {w_rem_sub,            acc_q[WIDTH-2:0], 1'b1}
                              : {w_rem_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};
    end

    // ------------------------------------------------------------------------
    // Sign correction, result select and flag generation
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_res;
    logic               w_ov;
    logic               w_legal;
    logic [3:0]         w_flags;

    // Final result and {OV, LT0, GT0, EQ0} for the finishing cycle
    always_comb begin
        w_prod  = neg_q ? -acc_q : acc_q;
        w_quot  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        w_res   = '1;
        w_ov    = 1'b0;
        w_legal = 1'b1;
        case (op_q)
            c_op_mullw: begin
                w_res = w_prod[WIDTH-1:0];
                // Overflow when the full signed product is not the sign
                // extension of its low half.
                w_ov  = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
            end
            c_op_mulhw, c_op_mulhwu: begin
                w_res = w_prod[2*WIDTH-1:WIDTH];
            end
            c_op_divw, c_op_divwu: begin
                if (fast_q) begin
                    w_res = '0;
                    w_ov  = 1'b1;
                end else begin
                    w_res = w_quot;
                end
            end
            default: begin
                w_res   = '1;
                w_legal = 1'b0;
            end
        endcase
        // CR0 is a signed compare with zero for every legal op; an illegal op
        // reports no flags at all.
        w_flags = w_legal ? {w_ov, w_res[WIDTH-1], ~w_res[WIDTH-1] & (|w_res), ~(|w_res)}
                          : 4'b0000;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Sequence IDLE -> MUL/DIV -> FIN -> IDLE, with flush aborting anywhere
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        bmag_d  = bmag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        fast_d  = fast_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        flags_d = flags_q;

        case (state_q)
            S_IDLE: begin
                // busy was held through the done cycle; it drops now unless a
                // new operation is taken in the same cycle.
                busy_d = 1'b0;
                if (start) begin
                    op_d   = Op;
                    bmag_d = w_b_mag;
                    acc_d  = {{WIDTH{1'b0}}, w_a_mag};
                    cnt_d  = c_last_iter;
                    neg_d  = w_a_neg ^ w_b_neg;
                    fast_d = w_fast;
                    busy_d = 1'b1;
                    if (w_op_mul) begin
                        state_d = S_MUL;
                    end else if (w_op_div && !w_fast) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_MUL: begin
                acc_d = w_mul_step;
                cnt_d = cnt_q - c_cnt_one;
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_DIV: begin
                acc_d = w_div_step;
                cnt_d = cnt_q - c_cnt_one;
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                res_d   = w_res;
                flags_d = w_flags;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush beats start and suppresses the result update and done pulse.
        if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            res_d   = res_q;
            flags_d = flags_q;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // All state and outputs, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            bmag_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            fast_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            bmag_q  <= bmag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            fast_q  <= fast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign C    = res_q;
    assign D    = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_muldiv_unit
// Brief    : Self-checking bench for iter_muldiv_unit: directed corner cases,
//            randomized operations against an arithmetic reference model,
//            start-ignore, flush and asynchronous reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_muldiv_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              flush;
    logic [2:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  c;
    logic [3:0]        d;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Variables used by the directed steps
    logic [WIDTH-1:0]  ec;
    logic [3:0]        ed;
    int                lat;
    int                cyc;
    int                base;
    logic [WIDTH-1:0]  hold_c;
    logic [3:0]        hold_d;
    logic [2:0]        rop;
    logic [WIDTH-1:0]  ra;
    logic [WIDTH-1:0]  rb;
    logic [2:0]        op_tbl [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd4, 3'd5, 3'd6};

    iter_muldiv_unit #(
        .WIDTH     (WIDTH),
        .OP_WIDTH  (3),
        .CNT_WIDTH (6)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .flush (flush),
        .Op    (op),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .C     (c),
        .D     (d)
    );

    always #5 clk = ~clk;

    // Count done pulses; done is sampled before the edge updates it
    always @(posedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rc, output logic [3:0] rd, output int rlat);
        longint     sx;
        longint     sy;
        longint     p;
        logic [63:0] up;
        logic       ov;
        logic       legal;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        ov    = 1'b0;
        legal = 1'b1;
        rlat  = WIDTH + 1;
        rc    = 32'd0;
        case (o)
            3'b000: begin
                p  = sx * sy;
                rc = p[31:0];
                ov = (p != longint'($signed(rc)));
            end
            3'b001: begin
                p  = sx * sy;
                rc = p[63:32];
            end
            3'b010: begin
                up = {32'd0, x} * {32'd0, y};
                rc = up[63:32];
            end
            3'b100: begin
                if (y == 32'd0 || (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) begin
                    rc = 32'd0; ov = 1'b1; rlat = 1;
                end else begin
                    p  = sx / sy;
                    rc = p[31:0];
                end
            end
            3'b101: begin
                if (y == 32'd0) begin
                    rc = 32'd0; ov = 1'b1; rlat = 1;
                end else begin
                    rc = x / y;
                end
            end
            default: begin
                rc = 32'hFFFF_FFFF; legal = 1'b0; rlat = 1;
            end
        endcase
        rd = legal ? {ov, $signed(rc) < 0, $signed(rc) > 0, rc == 32'd0} : 4'b0000;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 200)) - 32'd100;
            2: begin
                case ($urandom_range(0, 4))
                    0: return 32'd0;
                    1: return 32'd1;
                    2: return 32'hFFFF_FFFF;
                    3: return 32'h8000_0000;
                    default: return 32'h7FFF_FFFF;
                endcase
            end
            default: return 32'($urandom_range(0, 65535));
        endcase
    endfunction

    // Issue one operation, wait for done within a bound, check result and latency
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] xc;
        logic [3:0]  xd;
        int          xl;
        int          n;
        ref_op(o, x, y, xc, xd, xl);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(xl));
        chk({tag, " C"}, 64'(c), 64'(xc));
        chk({tag, " D"}, 64'(d), 64'(xd));
        chk({tag, " busy with done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({tag, " back to idle"}, 64'({busy, done}), 64'd0);
        hold_c = xc;
        hold_d = xd;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        hold_c = '0; hold_d = '0;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset C", 64'(c), 64'd0);
        chk("reset D", 64'(d), 64'd0);
        rst = 1'b0;

        // Directed corner cases
        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, "mullw 7*-3");
        run_op(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhwu max*max");
        run_op(3'b000, 32'h0001_0000,  32'h0001_0000, "mullw overflow");
        run_op(3'b001, 32'h8000_0000,  32'h8000_0000, "mulhw min*min");
        run_op(3'b001, 32'hFFFF_FFFF,  32'd5,         "mulhw -1*5");
        run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         "divw -7/2");
        run_op(3'b101, 32'd100,        32'd7,         "divwu 100/7");
        run_op(3'b100, 32'd5,          32'd0,         "divw by zero");
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, "divw overflow");
        run_op(3'b101, 32'hFFFF_FFFF,  32'd0,         "divwu by zero");
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFE, "divw min/-2");

        // Randomized operations against the model
        for (int i = 0; i < 24; i++) begin
            rop = op_tbl[$urandom_range(0, 9)];
            ra  = pick_operand();
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
            run_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
        end

        // A second start while busy is ignored and produces no extra done
        ref_op(3'b000, 32'd123, 32'hFFFF_FFD3, ec, ed, lat);
        base = done_seen;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd123; b = 32'hFFFF_FFD3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 6;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignore latency", 64'(cyc), 64'(lat));
        chk("ignore C", 64'(c), 64'(ec));
        chk("ignore D", 64'(d), 64'(ed));
        repeat (40) @(negedge clk);
        chk("ignore single done", 64'(done_seen - base), 64'd1);
        chk("ignore idle", 64'(busy), 64'd0);
        hold_c = ec; hold_d = ed;

        // Flush in the middle of a multiply, restart right after
        base = done_seen;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = $urandom; b = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush done", 64'(done), 64'd0);
        chk("flush C held", 64'(c), 64'(hold_c));
        chk("flush D held", 64'(d), 64'(hold_d));
        ref_op(3'b101, 32'd1000, 32'd3, ec, ed, lat);
        start = 1'b1; op = 3'b101; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("restart busy", 64'(busy), 64'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("restart latency", 64'(cyc), 64'(lat));
        chk("restart C", 64'(c), 64'(ec));
        chk("restart D", 64'(d), 64'(ed));
        repeat (3) @(negedge clk);
        chk("flush single done", 64'(done_seen - base), 64'd1);
        hold_c = ec; hold_d = ed;

        // Flush during FIN of an illegal op suppresses done and the update
        base = done_seen;
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = $urandom; b = $urandom;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("fin flush busy", 64'(busy), 64'd0);
        chk("fin flush done", 64'(done), 64'd0);
        chk("fin flush C held", 64'(c), 64'(hold_c));
        chk("fin flush D held", 64'(d), 64'(hold_d));
        repeat (3) @(negedge clk);
        chk("fin flush no done", 64'(done_seen - base), 64'd0);

        // Flush wins over a simultaneous start
        base = done_seen;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush over start busy", 64'(busy), 64'd0);
        repeat (36) @(negedge clk);
        chk("flush over start no done", 64'(done_seen - base), 64'd0);
        chk("flush over start C held", 64'(c), 64'(hold_c));

        // Asynchronous reset in the middle of a divide
        run_op(3'b101, 32'd100, 32'd7, "divwu pre-reset");
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = $urandom; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre-reset busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset done", 64'(done), 64'd0);
        chk("async reset C", 64'(c), 64'd0);
        chk("async reset D", 64'(d), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        base = done_seen;
        repeat (40) @(negedge clk);
        chk("post-reset no done", 64'(done_seen - base), 64'd0);
        run_op(3'b011, $urandom, $urandom, "illegal 011");
        run_op(3'b111, $urandom, $urandom, "illegal 111");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
